output_fifo_mc: RTL

//  N-lane output FIFO for the CIM result path. Each write pushes one wide row (NUM_LANES x LANE_WIDTH) into all lanes at once.

---
 rtl/output_fifo_pkg.sv | 18 +
 rtl/outfifo_lane_ptr.sv | 53 +++++
 rtl/output_fifo_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/output_fifo_pkg.sv
// -----------------------------------------------------------------------------
// output_fifo_pkg
// Shared definitions for the multi-lane output FIFO (output_fifo_mc).
//   RD_MODE_ADDR / RD_MODE_RR : encodings of the RD_MODE input
//   lane_lsb()                : bit offset of a lane inside a packed row
// No ports (package).
// -----------------------------------------------------------------------------
package output_fifo_pkg;

    localparam logic RD_MODE_ADDR = 1'b0;  // pop the lane named by RD_SEL
    localparam logic RD_MODE_RR   = 1'b1;  // pop lanes in round-robin order

    // Lane k of a row occupies row[lane_lsb(k, W) +: W].
    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/outfifo_lane_ptr.sv
// -----------------------------------------------------------------------------
// outfifo_lane_ptr
// Read pointer and occupancy counter for one FIFO lane. The row memory and
// the shared write pointer live in the top level; this block only tracks how
// far this lane has drained.
// Ports:
//   CLK        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   push       in   accepted row write this cycle
//   pop        in   accepted pop of this lane this cycle
//   rd_ptr     out  row index of this lane's oldest word
//   lane_empty out  lane holds 0 words
//   lane_full  out  lane holds DEPTH words
// -----------------------------------------------------------------------------
module outfifo_lane_ptr #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              lane_empty,
    output logic              lane_full
);

    // One extra bit so that DEPTH words is distinguishable from 0 words.
    logic [ADDR_W:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointer wraps naturally.
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign lane_empty = (count == '0);
    assign lane_full  = (count == (ADDR_W+1)'(DEPTH));

endmodule

// File: rtl/output_fifo_mc.sv
// -----------------------------------------------------------------------------
// output_fifo_mc
// N-lane output FIFO for the CIM result path. A write pushes one row
// (NUM_LANES x LANE_WIDTH) into every lane at once; lanes drain independently
// through one registered LANE_WIDTH read port, by explicit lane select or in
// round-robin order.
// Optional feature macro: OUTFIFO_ERR_EN (sticky overflow/underflow flags).
// Ports:
//   CLK        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   WR_EN      in   push one row into every lane
//   qin        in   row data, lane k = qin[k*LANE_WIDTH +: LANE_WIDTH]
//   RD_EN      in   pop one word
//   RD_MODE    in   0 = addressed (RD_SEL), 1 = round-robin
//   RD_SEL     in   lane to pop in addressed mode
//   RD_DATA    out  registered read word (holds when no pop)
//   RD_VALID   out  RD_DATA updated by a pop on the last edge
//   full       out  some lane holds DEPTH words
//   empty      out  some lane holds 0 words
//   lane_empty out  per-lane empty
//   err_clr    in   (OUTFIFO_ERR_EN) clear both sticky error flags
//   ovf_err    out  (OUTFIFO_ERR_EN) sticky: write attempted while full
//   udf_err    out  (OUTFIFO_ERR_EN) sticky: read rejected
// -----------------------------------------------------------------------------
module output_fifo_mc
    import output_fifo_pkg::*;
#(
    parameter int LANE_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SEL_W      = $clog2(NUM_LANES)
) (
    input  logic                            CLK,
    input  logic                            rst,
    input  logic                            WR_EN,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] qin,
    input  logic                            RD_EN,
    input  logic                            RD_MODE,
    input  logic [SEL_W-1:0]                RD_SEL,
    output logic [LANE_WIDTH-1:0]           RD_DATA,
    output logic                            RD_VALID,
    output logic                            full,
    output logic                            empty,
    output logic [NUM_LANES-1:0]            lane_empty
`ifdef OUTFIFO_ERR_EN
    ,
    input  logic                            err_clr,
    output logic                            ovf_err,
    output logic                            udf_err
`endif
);

    localparam int ROW_W = NUM_LANES * LANE_WIDTH;

    logic [ROW_W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [SEL_W-1:0]      rr_lane;
    logic [ADDR_W-1:0]     rd_ptr [NUM_LANES];
    logic [LANE_WIDTH-1:0] head [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_full;
    logic [NUM_LANES-1:0]  pop_vec;
    logic [SEL_W-1:0]      rd_lane;
    logic                  lane_ok;
    logic                  rd_ok;
    logic                  wr_ok;

    assign full  = |lane_full;
    assign empty = |lane_empty;

    // Read and write acceptance both look at pre-edge occupancy, so a read
    // of an empty lane never sees the row being written in the same cycle.
    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        pop_vec = '0;
        rd_lane = (RD_MODE == RD_MODE_RR) ? rr_lane : RD_SEL;
        lane_ok = int'(rd_lane) < NUM_LANES;
        rd_ok   = RD_EN && lane_ok && !lane_empty[rd_lane];
        wr_ok   = WR_EN && !full;
        if (rd_ok)
            pop_vec[rd_lane] = 1'b1;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        outfifo_lane_ptr #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ptr (
            .CLK        (CLK),
            .rst        (rst),
            .push       (wr_ok),
            .pop        (pop_vec[k]),
            .rd_ptr     (rd_ptr[k]),
            .lane_empty (lane_empty[k]),
            .lane_full  (lane_full[k])
        );

        // Oldest word of lane k.
        assign head[k] = mem[rd_ptr[k]][lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH];
    end

    // NOTE: the row memory has no reset; pointers and counts reset instead,
    // which makes any stale rows unreachable.
    always_ff @(posedge CLK) begin
        if (wr_ok)
            mem[wr_ptr] <= qin;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rr_lane  <= '0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                RD_DATA <= head[rd_lane];
            // Only round-robin pops move the round-robin cursor.
            if (rd_ok && RD_MODE == RD_MODE_RR)
                rr_lane <= (rr_lane == SEL_W'(NUM_LANES - 1)) ? '0 : rr_lane + 1'b1;
        end
    end

`ifdef OUTFIFO_ERR_EN
    // Sticky flags; a new error event takes priority over err_clr.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (WR_EN && full)
                ovf_err <= 1'b1;
            else if (err_clr)
                ovf_err <= 1'b0;

            if (RD_EN && !rd_ok)
                udf_err <= 1'b1;
            else if (err_clr)
                udf_err <= 1'b0;
        end
    end
`endif

endmodule
